// File: rtl/bram_2048x8.sv
// rtl/bram_2048x8.sv - 2048x8 true dual-port RAM, per-bit write masks, read-first, registered outputs.
module bram_2048x8 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE0,
    input  logic [10:0] A0,
    input  logic [7:0]  D0,
    input  logic        WE0,
    input  logic [7:0]  WEM0,
    output logic [7:0]  Q0,
    input  logic        CE1,
    input  logic [10:0] A1,
    input  logic [7:0]  D1,
    input  logic        WE1,
    input  logic [7:0]  WEM1,
    output logic [7:0]  Q1
);
    localparam int DEPTH = 2048;
    localparam int WIDTH = 8;

    logic [WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic             we0_eff;
    logic             we1_eff;
    logic [WIDTH-1:0] rd0_word;
    logic [WIDTH-1:0] rd1_word;
    logic [WIDTH-1:0] wr0_word;
    logic [WIDTH-1:0] wr1_base;
    logic [WIDTH-1:0] wr1_word;
    logic [WIDTH-1:0] q0_d, q0_q;
    logic [WIDTH-1:0] q1_d, q1_q;

    always_comb begin
        we0_eff  = CE0 & WE0;
        we1_eff  = CE1 & WE1;
        rd0_word = mem_q[A0];
        rd1_word = mem_q[A1];
        wr0_word = (rd0_word & ~WEM0) | (D0 & WEM0);
        // On a same-address collision port 1 merges on top of port 0's result,
        // so bits only port 0 enables survive and overlapping bits take port 1.
        wr1_base = (we0_eff && (A0 == A1)) ? wr0_word : rd1_word;
        wr1_word = (wr1_base & ~WEM1) | (D1 & WEM1);
        q0_d     = CE0 ? rd0_word : q0_q;
        q1_d     = CE1 ? rd1_word : q1_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q0_q <= '0;
            q1_q <= '0;
        end else begin
            q0_q <= q0_d;
            q1_q <= q1_d;
        end
    end

    // Array content is never reset; reset only blocks writes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (we0_eff) mem_q[A0] <= wr0_word;
            if (we1_eff) mem_q[A1] <= wr1_word;
        end
    end

    assign Q0 = q0_q;
    assign Q1 = q1_q;
endmodule

// File: tb/tb_bram_2048x8.sv
// tb/tb_bram_2048x8.sv - scoreboard bench for bram_2048x8 with directed vectors.
module tb_bram_2048x8;
    logic        CLK = 1'b0;
    logic        RST;
    logic        CE0, WE0, CE1, WE1;
    logic [10:0] A0, A1;
    logic [7:0]  D0, WEM0, D1, WEM1;
    logic [7:0]  Q0, Q1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] e0;
        logic [7:0] e1;
        string      nm;
    } exp_t;

    exp_t sb[$];

    bram_2048x8 dut (
        .CLK(CLK), .RST(RST),
        .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0), .Q0(Q0),
        .CE1(CE1), .A1(A1), .D1(D1), .WE1(WE1), .WEM1(WEM1), .Q1(Q1)
    );

    always #5 CLK = ~CLK;

    // Monitor: every clocked access produces a new Q pair; check it away from the edge.
    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total = total + 2;
            if (Q0 !== e.e0) begin
                bad = bad + 1;
                $display("FAIL %s Q0 got=%02h exp=%02h", e.nm, Q0, e.e0);
            end
            if (Q1 !== e.e1) begin
                bad = bad + 1;
                $display("FAIL %s Q1 got=%02h exp=%02h", e.nm, Q1, e.e1);
            end
        end
    end

    task automatic cyc(
        input logic c0, input logic [10:0] a0, input logic [7:0] d0, input logic w0, input logic [7:0] m0,
        input logic c1, input logic [10:0] a1, input logic [7:0] d1, input logic w1, input logic [7:0] m1,
        input logic [7:0] e0, input logic [7:0] e1, input string nm);
        exp_t e;
        CE0 = c0; A0 = a0; D0 = d0; WE0 = w0; WEM0 = m0;
        CE1 = c1; A1 = a1; D1 = d1; WE1 = w1; WEM1 = m1;
        @(posedge CLK);
        e.e0 = e0; e.e1 = e1; e.nm = nm;
        sb.push_back(e);
        #1;
    endtask

    task automatic check_now(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%02h exp=%02h", nm, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        CE0 = 0; WE0 = 0; A0 = '0; D0 = '0; WEM0 = '0;
        CE1 = 0; WE1 = 0; A1 = '0; D1 = '0; WEM1 = '0;
        #2;
        check_now("reset_q0", Q0, 8'h00);
        check_now("reset_q1", Q1, 8'h00);
        @(negedge CLK);
        RST = 1'b0;

        //  ce0 a0      d0     we0 wem0    ce1 a1      d1     we1 wem1    exp Q0 exp Q1
        cyc(1, 11'h000, 8'hA5, 1, 8'hFF,   0, 11'h000, 8'h00, 0, 8'h00,   8'h00, 8'h00, "wr0_a5");
        cyc(0, 11'h000, 8'h00, 0, 8'h00,   1, 11'h000, 8'h00, 0, 8'h00,   8'h00, 8'hA5, "cross_rd_a5");
        cyc(1, 11'h7FF, 8'hFF, 1, 8'hFF,   0, 11'h000, 8'h00, 0, 8'h00,   8'h00, 8'hA5, "wr_7ff_ff");
        cyc(1, 11'h7FF, 8'h00, 1, 8'h0F,   0, 11'h000, 8'h00, 0, 8'h00,   8'hFF, 8'hA5, "mask_read_first");
        cyc(0, 11'h000, 8'h00, 0, 8'h00,   1, 11'h7FF, 8'h00, 0, 8'h00,   8'hFF, 8'hF0, "mask_result");
        cyc(1, 11'h123, 8'h3C, 1, 8'hFF,   1, 11'h123, 8'h00, 0, 8'h00,   8'h00, 8'h00, "cross_rw_same");
        cyc(1, 11'h123, 8'h00, 0, 8'h00,   1, 11'h123, 8'h00, 0, 8'h00,   8'h3C, 8'h3C, "dual_rd_same");
        cyc(1, 11'h055, 8'h11, 1, 8'hFF,   1, 11'h055, 8'h22, 1, 8'hF0,   8'h00, 8'h00, "dual_wr");
        cyc(1, 11'h055, 8'h00, 0, 8'h00,   0, 11'h000, 8'h00, 0, 8'h00,   8'h21, 8'h00, "dual_wr_merge");
        cyc(0, 11'h000, 8'h00, 0, 8'h00,   1, 11'h055, 8'hFF, 1, 8'h00,   8'h21, 8'h21, "wem_zero_rd");
        cyc(1, 11'h055, 8'h00, 0, 8'h00,   1, 11'h055, 8'h00, 0, 8'h00,   8'h21, 8'h21, "wem_zero_kept");
        cyc(1, 11'h400, 8'hC3, 1, 8'hFF,   1, 11'h000, 8'h00, 0, 8'h00,   8'h00, 8'hA5, "wr_400");
        cyc(1, 11'h400, 8'h00, 0, 8'h00,   1, 11'h000, 8'h00, 0, 8'h00,   8'hC3, 8'hA5, "no_alias");
        cyc(1, 11'h200, 8'h5A, 1, 8'hFF,   0, 11'h000, 8'h00, 0, 8'h00,   8'h00, 8'hA5, "wr_200");
        cyc(1, 11'h200, 8'h00, 0, 8'h00,   0, 11'h000, 8'h00, 0, 8'h00,   8'h5A, 8'hA5, "rd_200");

        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check_now("async_rst_q0", Q0, 8'h00);
        check_now("async_rst_q1", Q1, 8'h00);
        cyc(1, 11'h200, 8'h00, 1, 8'hFF,   1, 11'h010, 8'hEE, 1, 8'hFF,   8'h00, 8'h00, "in_reset_a");
        cyc(1, 11'h200, 8'h00, 1, 8'hFF,   1, 11'h010, 8'hEE, 1, 8'hFF,   8'h00, 8'h00, "in_reset_b");
        @(negedge CLK);
        RST = 1'b0;

        cyc(1, 11'h200, 8'h00, 0, 8'h00,   1, 11'h010, 8'h00, 0, 8'h00,   8'h5A, 8'h00, "post_reset_rd");
        cyc(0, 11'h000, 8'h00, 0, 8'h00,   1, 11'h010, 8'h77, 1, 8'hFF,   8'h5A, 8'h00, "wr_010");
        cyc(0, 11'h000, 8'h00, 0, 8'h00,   1, 11'h010, 8'h00, 0, 8'h00,   8'h5A, 8'h77, "rd_010");
        cyc(0, 11'h200, 8'hAA, 1, 8'hFF,   0, 11'h010, 8'hAA, 1, 8'hFF,   8'h5A, 8'h77, "ce_off_1");
        cyc(0, 11'h201, 8'h55, 1, 8'hFF,   0, 11'h011, 8'h55, 1, 8'hFF,   8'h5A, 8'h77, "ce_off_2");
        cyc(0, 11'h200, 8'hCC, 1, 8'hFF,   0, 11'h010, 8'hCC, 1, 8'hFF,   8'h5A, 8'h77, "ce_off_3");
        cyc(1, 11'h010, 8'h00, 0, 8'h00,   1, 11'h011, 8'h00, 0, 8'h00,   8'h77, 8'h00, "ce_off_mem");
        cyc(1, 11'h200, 8'h00, 0, 8'h00,   1, 11'h201, 8'h00, 0, 8'h00,   8'h5A, 8'h00, "ce_off_mem0");
        cyc(1, 11'h7FF, 8'h00, 0, 8'h00,   1, 11'h400, 8'h00, 0, 8'h00,   8'hF0, 8'hC3, "final_rd");

        @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_2048x8.md
BRAM_2048X8 -- requirements
Module: bram_2048x8

Interface
REQ-001: DEPTH, 2048, number of words; fixed, not overridable.
REQ-002: WIDTH, 8, bits per word; fixed, not overridable.
REQ-003: CLK  input  1  sole clock; all state changes on the rising edge except reset.
REQ-004: RST  input  1  reset, asynchronous, active-high.
REQ-005: CE0  input  1  port 0 enable.
REQ-006: A0  input  11  port 0 word address.
REQ-007: D0  input  8  port 0 write data.
REQ-008: WE0  input  1  port 0 write enable; effective only with CE0=1.
REQ-009: WEM0  input  8  port 0 per-bit write mask; 1 = bit written.
REQ-010: Q0  output  8  port 0 registered read data.
REQ-011: CE1  input  1  port 1 enable.
REQ-012: A1  input  11  port 1 word address.
REQ-013: D1  input  8  port 1 write data.
REQ-014: WE1  input  1  port 1 write enable; effective only with CE1=1.
REQ-015: WEM1  input  8  port 1 per-bit write mask.
REQ-016: Q1  output  8  port 1 registered read data.

Function
REQ-017: Storage is a 2048 x 8 array shared by two fully independent, symmetric read/write ports on CLK.
REQ-018: Port p with CEp=1 at a rising edge reads mem[Ap] into Qp; read latency is exactly 1 cycle.
REQ-019: Port p with CEp=1 and WEp=1 at a rising edge updates each bit i of mem[Ap] where WEMp[i]=1 to Dp[i]; bits with WEMp[i]=0 keep their value.
REQ-020: WEp=1 with WEMp=0 leaves the array unchanged and still performs the read.
REQ-021: Read-first on a write: Qp shows the word content before that edge's write, not the new data.
REQ-022: Port p with CEp=0 performs no access; Qp holds its last value; WEp, WEMp, Ap and Dp are ignored.
REQ-023: Cross-port read/write to the same address in one cycle: the reading port returns the pre-write content.
REQ-024: Both ports writing the same address in one cycle: for bits enabled in both masks port 1 data wins; bits enabled in one mask only take that port's data.
REQ-025: Both ports reading the same address return identical data.
REQ-026: All 11 address bits decode to a distinct word; there is no aliasing and no out-of-range address.
REQ-027: Array content is all-zero at time zero in simulation; no reset of the array content.

Reset
REQ-028: RST=1 forces Q0=0 and Q1=0 immediately, independent of CLK.
REQ-029: While RST=1, rising edges perform no reads and no writes, and Q0/Q1 stay 0.
REQ-030: Array content is preserved across reset, including reset asserted mid-operation.
REQ-031: The first rising edge after RST falls with CEp=1 performs a normal access; the result appears on Qp one cycle later.

Verification
REQ-032: Write 0xA5 to A0=0x000 with WEM0=0xFF, then read A1=0x000 on the next cycle -> Q1=0xA5 one cycle after the read edge.
REQ-033: mem[0x7FF]=0xFF, then port 0 writes D0=0x00 with WEM0=0x0F -> a later read of 0x7FF returns 0xF0; Q0 during the write cycle is 0xFF (read-first).
REQ-034: Same cycle, port 0 writes 0x3C to 0x123 (old value 0x00) while port 1 reads 0x123 -> Q1=0x00; next read of 0x123 -> 0x3C.
REQ-035: Same cycle, both ports write 0x055, D0=0x11 with WEM0=0xFF and D1=0x22 with WEM1=0xF0 -> a later read returns 0x21.
REQ-036: Q0=0x5A, then assert RST between clock edges -> Q0=0 at once; after release, reading the previously written address returns its stored value.
REQ-037: Port p reads 0x010 (value 0x77), then CEp=0 for 3 cycles while Ap and Dp toggle with WEp=1 -> Qp stays 0x77 and mem[Ap] is unchanged.
